// File: rtl/dff_pipe.sv
// ----------------------------------------------------------------------------
// dff_pipe
//   Parametrised D-register pipeline. Delays a WIDTH-bit word by DEPTH
//   clock-enabled stages and carries a valid tag with every word. It supports
//   stall (en) and flush, and reports how many stages hold valid words.
//
//   Parameters
//     WIDTH      data width in bits, >= 1
//     DEPTH      number of register stages, >= 1
//     RESET_VAL  value loaded into every data stage on reset
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-low reset
//     en         advance the pipeline by one stage
//     flush      invalidate every stage; data stages keep their values
//     d          input data word
//     d_valid    valid tag for d
//     q          data word of the last stage
//     q_valid    valid tag of the last stage
//     occupancy  number of stages whose valid tag is 1
//
//   Valid semantics: d_valid is a tag only. There is no ready or backpressure
//   signal. On every edge with reset=1, flush=0 and en=1, the pair
//   (d, d_valid) is captured. A word with d_valid=0 still moves through the
//   pipeline as a bubble. q_valid=1 marks q as a real word.
//
//   Update priority on each rising edge: reset > flush > en > hold.
//   All outputs come straight from registers.
// ----------------------------------------------------------------------------
module dff_pipe #(
   parameter int               WIDTH     = 4,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [OCC_W-1:0] occupancy
);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("dff_pipe: DEPTH must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] stage [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [OCC_W-1:0] occ;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= RESET_VAL;
         end
         vld <= '0;
         occ <= '0;
      end else if (flush) begin
         vld <= '0;
         occ <= '0;
      end else if (en) begin
         stage[0] <= d;
         vld[0]   <= d_valid;
         for (int i = DEPTH - 1; i > 0; i--) begin
            stage[i] <= stage[i-1];
            vld[i]   <= vld[i-1];
         end
         // One word may enter and one may leave on the same edge. The true
         // result always lies in 0..DEPTH. Modular arithmetic therefore gives
         // the right value even when the intermediate sum overflows OCC_W.
         occ <= occ + OCC_W'(d_valid) - OCC_W'(vld[DEPTH-1]);
      end
   end

   assign q         = stage[DEPTH-1];
   assign q_valid   = vld[DEPTH-1];
   assign occupancy = occ;

endmodule

// File: tb/tb_dff_pipe.sv
// ----------------------------------------------------------------------------
// tb_dff_pipe
//   Bench for dff_pipe. It drives a WIDTH=4/DEPTH=4 instance and a
//   WIDTH=8/DEPTH=1 instance from one clock.
//
//   The bench keeps its own shadow model of the stages. Occupancy is taken
//   as a popcount of the shadow valid bits. The bench also keeps a queue of
//   accepted valid words. That queue is popped whenever the model says a
//   valid word has reached the output.
// ----------------------------------------------------------------------------
module tb_dff_pipe;

   logic       tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // DEPTH=4 instance
   logic       reset, en, flush, d_valid;
   logic [3:0] d;
   logic [3:0] q;
   logic       q_valid;
   logic [2:0] occupancy;

   // DEPTH=1 instance
   logic       reset1, en1, flush1, d_valid1;
   logic [7:0] d1;
   logic [7:0] q1;
   logic       q_valid1;
   logic [0:0] occupancy1;

   dff_pipe #(.WIDTH(4), .DEPTH(4), .RESET_VAL(4'h0)) u_dut4 (
      .clk(tb_clk), .reset(reset), .en(en), .flush(flush),
      .d(d), .d_valid(d_valid),
      .q(q), .q_valid(q_valid), .occupancy(occupancy)
   );

   dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
      .clk(tb_clk), .reset(reset1), .en(en1), .flush(flush1),
      .d(d1), .d_valid(d_valid1),
      .q(q1), .q_valid(q_valid1), .occupancy(occupancy1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Shadow model and scoreboard.
   logic [3:0] m_stage [4];
   logic       m_vld   [4];
   int         m_occ;
   logic [3:0] exp_q [$];
   logic       sb_have;
   logic [3:0] sb_exp;

   // Apply one cycle of inputs to the DEPTH=4 instance and advance the clock.
   // Then update the shadow model and the scoreboard.
   task automatic drive_cycle(input logic rst, input logic fl, input logic e,
                              input logic dv, input logic [3:0] dd);
      reset = rst; flush = fl; en = e; d_valid = dv; d = dd;
      @(posedge tb_clk);
      sb_have = 1'b0;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            m_stage[i] = 4'h0;
            m_vld[i]   = 1'b0;
         end
         exp_q.delete();
      end else if (fl) begin
         for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
         exp_q.delete();
      end else if (e) begin
         for (int i = 3; i > 0; i--) begin
            m_stage[i] = m_stage[i-1];
            m_vld[i]   = m_vld[i-1];
         end
         m_stage[0] = dd;
         m_vld[0]   = dv;
         if (dv) exp_q.push_back(dd);
         if (m_vld[3] && exp_q.size() > 0) begin
            sb_exp  = exp_q.pop_front();
            sb_have = 1'b1;
         end
      end
      m_occ = 0;
      for (int i = 0; i < 4; i++) m_occ += int'(m_vld[i]);
      #1;
   endtask

   task automatic test_reset();
      reset1 = 1'b0; flush1 = 1'b0; en1 = 1'b1; d_valid1 = 1'b1; d1 = 8'hFF;
      for (int c = 0; c < 2; c++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
         n_checks++;
         if (q !== 4'h0 || q_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_c%0d: q=%h q_valid=%b occ=%0d, want q=0 q_valid=0 occ=0",
                     c, q, q_valid, occupancy);
         end
         n_checks++;
         if (q1 !== 8'h00 || q_valid1 !== 1'b0 || occupancy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset1_c%0d: q=%h q_valid=%b occ=%0d, want 00/0/0",
                     c, q1, q_valid1, occupancy1);
         end
      end
   endtask

   task automatic test_stream();
      int want_occ;
      for (int k = 0; k < 16; k++) begin
         drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'(k));
         want_occ = (k < 3) ? k + 1 : 4;
         n_checks++;
         if (occupancy !== 3'(want_occ)) begin
            n_fail++;
            $display("FAIL stream_occ k=%0d: got %0d want %0d", k, occupancy, want_occ);
         end
         n_checks++;
         if (q_valid !== (k >= 3)) begin
            n_fail++;
            $display("FAIL stream_qv k=%0d: got %b want %b", k, q_valid, (k >= 3));
         end
         if (k >= 3) begin
            n_checks++;
            if (q !== 4'(k - 3)) begin
               n_fail++;
               $display("FAIL stream_q k=%0d: got %h want %h", k, q, 4'(k - 3));
            end
         end
         if (sb_have) begin
            n_checks++;
            if (q !== sb_exp) begin
               n_fail++;
               $display("FAIL stream_sb k=%0d: got %h want %h", k, q, sb_exp);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [3:0] held_q;
      logic [2:0] held_occ;
      int         w;
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      w = 1;
      // Words 1..8, then four bubbles to drain. En drops for 3 cycles after
      // word 5 has entered.
      for (int c = 0; c < 15; c++) begin
         logic e;
         logic dv;
         e  = !(c >= 5 && c <= 7);
         dv = (w <= 8);
         held_q   = q;
         held_occ = occupancy;
         drive_cycle(1'b1, 1'b0, e, dv, dv ? 4'(w) : 4'(c));
         if (e && dv) w++;
         if (!e) begin
            n_checks++;
            if (q !== held_q || occupancy !== held_occ) begin
               n_fail++;
               $display("FAIL stall_frozen c=%0d: q=%h occ=%0d, want q=%h occ=%0d",
                        c, q, occupancy, held_q, held_occ);
            end
         end
         n_checks++;
         if (q !== m_stage[3] || q_valid !== m_vld[3] || occupancy !== 3'(m_occ)) begin
            n_fail++;
            $display("FAIL stall_model c=%0d: q=%h qv=%b occ=%0d, want %h/%b/%0d",
                     c, q, q_valid, occupancy, m_stage[3], m_vld[3], m_occ);
         end
         if (sb_have) begin
            n_checks++;
            if (q !== sb_exp || q_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL stall_sb c=%0d: q=%h qv=%b, want %h/1", c, q, q_valid, sb_exp);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0 || w != 9) begin
         n_fail++;
         $display("FAIL stall_drain: %0d words outstanding, next word %0d, want 0 and 9",
                  exp_q.size(), w);
      end
   endtask

   task automatic test_flush();
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int k = 1; k <= 4; k++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'(k + 4));
      n_checks++;
      if (occupancy !== 3'd4 || q_valid !== 1'b1 || q !== 4'h5) begin
         n_fail++;
         $display("FAIL flush_load: q=%h qv=%b occ=%0d, want 5/1/4", q, q_valid, occupancy);
      end
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
      n_checks++;
      if (q_valid !== 1'b0 || occupancy !== 3'd0 || q !== 4'h5) begin
         n_fail++;
         $display("FAIL flush_clear: q=%h qv=%b occ=%0d, want 5/0/0", q, q_valid, occupancy);
      end
      // Only bubbles follow. 4'hA must never show up as a valid word.
      for (int c = 0; c < 6; c++) begin
         drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'(c));
         n_checks++;
         if (q_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_after c=%0d: q=%h qv=%b occ=%0d, want qv=0 occ=0",
                     c, q, q_valid, occupancy);
         end
      end
   endtask

   task automatic test_alternate();
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int c = 0; c < 12; c++) begin
         drive_cycle(1'b1, 1'b0, 1'b1, (c % 2 == 0), 4'($urandom_range(0, 15)));
         if (c >= 3) begin
            n_checks++;
            if (q_valid !== (c % 2 == 1)) begin
               n_fail++;
               $display("FAIL alt_qv c=%0d: got %b want %b", c, q_valid, (c % 2 == 1));
            end
         end
         n_checks++;
         if (q !== m_stage[3] || occupancy !== 3'(m_occ)) begin
            n_fail++;
            $display("FAIL alt_model c=%0d: q=%h occ=%0d, want %h/%0d",
                     c, q, occupancy, m_stage[3], m_occ);
         end
         if (sb_have) begin
            n_checks++;
            if (q !== sb_exp) begin
               n_fail++;
               $display("FAIL alt_sb c=%0d: got %h want %h", c, q, sb_exp);
            end
         end
      end
      n_checks++;
      if (occupancy !== 3'd2) begin
         n_fail++;
         $display("FAIL alt_settle: occ=%0d want 2", occupancy);
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
      n_checks++;
      if (q !== 4'h0 || q_valid !== 1'b0 || occupancy !== 3'd0) begin
         n_fail++;
         $display("FAIL alt_reset: q=%h qv=%b occ=%0d, want 0/0/0", q, q_valid, occupancy);
      end
   endtask

   task automatic test_depth1();
      reset1 = 1'b1; flush1 = 1'b0; en1 = 1'b1; d_valid1 = 1'b1; d1 = 8'h5A;
      @(posedge tb_clk); #1;
      n_checks++;
      if (q1 !== 8'h5A || q_valid1 !== 1'b1 || occupancy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL d1_load: q=%h qv=%b occ=%0d, want 5A/1/1", q1, q_valid1, occupancy1);
      end
      en1 = 1'b0; d1 = 8'hFF; d_valid1 = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge tb_clk); #1;
         n_checks++;
         if (q1 !== 8'h5A || q_valid1 !== 1'b1 || occupancy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_hold c=%0d: q=%h qv=%b occ=%0d, want 5A/1/1",
                     c, q1, q_valid1, occupancy1);
         end
      end
      en1 = 1'b1;
      @(posedge tb_clk); #1;
      n_checks++;
      if (q1 !== 8'hFF || q_valid1 !== 1'b0 || occupancy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL d1_bubble: q=%h qv=%b occ=%0d, want FF/0/0", q1, q_valid1, occupancy1);
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = '0;
      reset1 = 1'b0; en1 = 1'b0; flush1 = 1'b0; d_valid1 = 1'b0; d1 = '0;
      for (int i = 0; i < 4; i++) begin
         m_stage[i] = 4'h0;
         m_vld[i]   = 1'b0;
      end
      m_occ = 0;
      sb_have = 1'b0;
      sb_exp  = '0;
      @(negedge tb_clk);
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_alternate();
      test_depth1();
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
